// File: rtl/ncl_seq_pkg.sv
// rtl/ncl_seq_pkg.sv - shared types and constants for the NCL counter sequencer
package ncl_seq_pkg;

  typedef enum logic [2:0] {
    RST_NULL   = 3'd0,
    IDLE       = 3'd1,
    DRIVE_DATA = 3'd2,
    WAIT_DATA  = 3'd3,
    DRIVE_NULL = 3'd4,
    WAIT_NULL  = 3'd5,
    RESPOND    = 3'd6
  } state_e;

  localparam logic OP_READ = 1'b0;
  localparam logic OP_INC  = 1'b1;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ONE  = 2'b10;

endpackage

// File: rtl/ncl_completeness_sync.sv
// rtl/ncl_completeness_sync.sv - dual-rail completeness detection and synchronizers
module ncl_completeness_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] sum_rails,
  input  logic [1:0]         carry_out,
  output logic               data_done,
  output logic               null_done,
  output logic               illegal
);

  logic data_raw, null_raw, illegal_raw;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] null_sync_q, null_sync_d;
  logic [SYNC_STAGES-1:0] ill_sync_q, ill_sync_d;

  // Each flag is a single async bit; the ring is quiescent while a flag holds.
  always_comb begin
    data_raw    = carry_out[1] ^ carry_out[0];
    illegal_raw = &carry_out;
    for (int k = 0; k < WIDTH; k++) begin
      data_raw    = data_raw & (sum_rails[2*k+1] ^ sum_rails[2*k]);
      illegal_raw = illegal_raw | (sum_rails[2*k+1] & sum_rails[2*k]);
    end
    null_raw = ~(|sum_rails) & ~(|carry_out);
  end

  always_comb begin
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data_raw};
    null_sync_d = {null_sync_q[SYNC_STAGES-2:0], null_raw};
    ill_sync_d  = {ill_sync_q[SYNC_STAGES-2:0], illegal_raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_q <= '0;
      null_sync_q <= '0;
      ill_sync_q  <= '0;
    end else begin
      data_sync_q <= data_sync_d;
      null_sync_q <= null_sync_d;
      ill_sync_q  <= ill_sync_d;
    end
  end

  assign data_done = data_sync_q[SYNC_STAGES-1];
  assign null_done = null_sync_q[SYNC_STAGES-1];
  assign illegal   = ill_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_counter_sequencer.sv
// rtl/ncl_counter_sequencer.sv - clocked wavefront sequencer for the dual-rail NCL ring counter
module ncl_counter_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [CNT_W-1:0]   cmd_count,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_value,
  output logic               rsp_carry,
  output logic               rsp_err,
  output logic               busy,
  output logic               ring_init,
  output logic               ring_ki,
  output logic [1:0]         carry_in,
  input  logic [2*WIDTH-1:0] sum_rails,
  input  logic [1:0]         carry_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic data_done, null_done, illegal;

  ncl_completeness_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (init_n),
    .sum_rails (sum_rails),
    .carry_out (carry_out),
    .data_done (data_done),
    .null_done (null_done),
    .illegal   (illegal)
  );

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [1:0]         init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_value_q, rsp_value_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               ring_init_q, ring_init_d;
  logic               ring_ki_q, ring_ki_d;
  logic [1:0]         carry_in_q, carry_in_d;
  logic [WIDTH-1:0]   sum_rail1;
  logic               tmo_hit;
  logic               data_phase;

  always_comb begin
    sum_rail1 = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum_rail1[k] = sum_rails[2*k+1];
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    steps_d     = steps_q;
    tmo_d       = tmo_q + TW'(1);
    init_cnt_d  = init_cnt_q;
    val_d       = val_q;
    carry_d     = carry_q;
    err_d       = err_q;

    case (state_q)
      RST_NULL: begin
        if (init_cnt_q != 2'd2) init_cnt_d = init_cnt_q + 2'd1;
        if (!ring_init_q && null_done) state_d = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          op_d    = (cmd_op == OP_INC) && (cmd_count != '0);
          steps_d = (op_d == OP_INC) ? cmd_count : CNT_W'(1);
          carry_d = 1'b0;
          err_d   = 1'b0;
          state_d = DRIVE_DATA;
        end
      end
      DRIVE_DATA: state_d = WAIT_DATA;
      WAIT_DATA: begin
        if (illegal) err_d = 1'b1;
        if (data_done) begin
          val_d = sum_rail1;
          if (carry_out == DR_ONE) carry_d = 1'b1;
          state_d = DRIVE_NULL;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = DRIVE_NULL;
        end
      end
      DRIVE_NULL: state_d = WAIT_NULL;
      WAIT_NULL: begin
        if (null_done) begin
          steps_d = steps_q - CNT_W'(1);
          // An error abandons whatever steps remain.
          state_d = (steps_q > CNT_W'(1) && !err_q) ? DRIVE_DATA : RESPOND;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = RST_NULL;
    endcase

    if (state_d != state_q) tmo_d = '0;

    data_phase  = (state_d == DRIVE_DATA) || (state_d == WAIT_DATA);
    ring_init_d = (state_d == RST_NULL) && (init_cnt_d != 2'd2);
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    ring_ki_d   = !data_phase;
    carry_in_d  = data_phase ? ((op_d == OP_INC) ? DR_ONE : DR_ZERO) : DR_NULL;
    rsp_valid_d = (state_d == RESPOND);

    rsp_value_d = rsp_value_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    if (state_d == RESPOND && state_q != RESPOND) begin
      rsp_value_d = val_d;
      rsp_carry_d = carry_d;
      rsp_err_d   = err_d;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= RST_NULL;
      op_q        <= OP_READ;
      steps_q     <= '0;
      tmo_q       <= '0;
      init_cnt_q  <= '0;
      val_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_value_q <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b1;
      ring_init_q <= 1'b1;
      ring_ki_q   <= 1'b1;
      carry_in_q  <= DR_NULL;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      steps_q     <= steps_d;
      tmo_q       <= tmo_d;
      init_cnt_q  <= init_cnt_d;
      val_q       <= val_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_value_q <= rsp_value_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      ring_init_q <= ring_init_d;
      ring_ki_q   <= ring_ki_d;
      carry_in_q  <= carry_in_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_value = rsp_value_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign ring_init = ring_init_q;
  assign ring_ki   = ring_ki_q;
  assign carry_in  = carry_in_q;

endmodule

// File: tb/tb_ncl_counter_sequencer.sv
// tb/tb_ncl_counter_sequencer.sv - directed bench with a behavioural 4-bit dual-rail ring model
module tb_ncl_counter_sequencer;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               init_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_op = 1'b0;
  logic [CNT_W-1:0]   cmd_count = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [WIDTH-1:0]   rsp_value;
  logic               rsp_carry;
  logic               rsp_err;
  logic               busy;
  logic               ring_init;
  logic               ring_ki;
  logic [1:0]         carry_in;
  logic [2*WIDTH-1:0] sum_rails = '0;
  logic [1:0]         carry_out = 2'b00;

  int vectors = 0;
  int miscompares = 0;

  ncl_counter_sequencer #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .init_n(init_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_value(rsp_value), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy),
    .ring_init(ring_init), .ring_ki(ring_ki), .carry_in(carry_in),
    .sum_rails(sum_rails), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Ring model: one wavefront per DATA/NULL handshake, updated away from the DUT edge.
  logic [WIDTH-1:0] ring_val = '0;
  logic [WIDTH:0]   pend = '0;
  bit data_phase = 1'b0;
  bit fault_null = 1'b0;
  bit fault_ill  = 1'b0;
  int n_d1 = 0, n_d0 = 0, n_null = 0;

  always @(negedge clk) begin
    if (ring_init) begin
      ring_val   = '0;
      sum_rails  = '0;
      carry_out  = 2'b00;
      data_phase = 1'b0;
    end else if (!ring_ki && carry_in != 2'b00 && !data_phase) begin
      data_phase = 1'b1;
      if (carry_in == 2'b10) n_d1++; else n_d0++;
      pend = {1'b0, ring_val} + ((carry_in == 2'b10) ? 5'd1 : 5'd0);
      for (int k = 0; k < WIDTH; k++) begin
        sum_rails[2*k+1] = pend[k];
        sum_rails[2*k]   = ~pend[k];
      end
      carry_out = pend[WIDTH] ? 2'b10 : 2'b01;
      if (fault_null) sum_rails[1:0] = 2'b00;
      if (fault_ill)  sum_rails[1:0] = 2'b11;
    end else if (ring_ki && carry_in == 2'b00 && data_phase) begin
      data_phase = 1'b0;
      n_null++;
      ring_val  = pend[WIDTH-1:0];
      sum_rails = '0;
      carry_out = 2'b00;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_cmd(input logic op, input logic [CNT_W-1:0] cnt, input int hold,
                        output logic [WIDTH-1:0] v, output logic c, output logic e,
                        output int data_cycles);
    int n;
    bit stable;
    wait_ready();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    data_cycles = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      if (carry_in != 2'b00) data_cycles++;
      @(posedge clk); #1; n++;
    end
    chk("rsp_arrive", rsp_valid, 1);
    v = rsp_value; c = rsp_carry; e = rsp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_value !== v || rsp_carry !== c ||
          rsp_err !== e || cmd_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk("rsp_hold_stable", stable, 1);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("rsp_release", rsp_valid, 0);
  endtask

  logic [WIDTH-1:0] v;
  logic c, e;
  int dc;

  initial begin
    // Reset values while init_n is low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ring_init", ring_init, 1);
    chk("rst_ring_ki", ring_ki, 1);
    chk("rst_carry_in", carry_in, 2'b00);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rsp", {rsp_valid, rsp_carry, rsp_err, 28'(rsp_value)}, 0);

    @(negedge clk); init_n = 1'b1;
    @(posedge clk); #1;
    chk("init_pulse_c1", ring_init, 1);
    @(posedge clk); #1;
    chk("init_pulse_c2", ring_init, 0);
    wait_ready();
    chk("idle_busy", busy, 0);
    chk("idle_rsp", {rsp_valid, rsp_carry, rsp_err, 28'(rsp_value)}, 0);

    // READ after reset.
    n_d0 = 0; n_d1 = 0; n_null = 0;
    do_cmd(1'b0, 8'd0, 0, v, c, e, dc);
    chk("read0_value", v, 0);
    chk("read0_carry_err", {c, e}, 0);
    chk("read0_waves", {8'(n_d0), 8'(n_d1), 8'(n_null)}, {8'd1, 8'd0, 8'd1});
    chk("read0_ring", ring_val, 0);

    // INC 5, then READ with the response held off for 20 cycles.
    n_d0 = 0; n_d1 = 0; n_null = 0;
    do_cmd(1'b1, 8'd5, 0, v, c, e, dc);
    chk("inc5_value", v, 5);
    chk("inc5_carry_err", {c, e}, 0);
    chk("inc5_waves", {8'(n_d0), 8'(n_d1), 8'(n_null)}, {8'd0, 8'd5, 8'd5});
    do_cmd(1'b0, 8'd3, 20, v, c, e, dc);
    chk("read5_value", v, 5);
    chk("read5_carry_err", {c, e}, 0);

    // INC with count 0 behaves as READ.
    n_d0 = 0; n_d1 = 0;
    do_cmd(1'b1, 8'd0, 0, v, c, e, dc);
    chk("inc0_value", v, 5);
    chk("inc0_waves", {8'(n_d0), 8'(n_d1)}, {8'd1, 8'd0});

    // Sum pair stuck at NULL: timeout after TIMEOUT+1 cycles in WAIT_DATA, rest abandoned.
    fault_null = 1'b1; n_d1 = 0;
    do_cmd(1'b1, 8'd3, 0, v, c, e, dc);
    chk("stuck_err", e, 1);
    chk("stuck_data_cycles", dc, TIMEOUT + 2);
    chk("stuck_waves", n_d1, 1);
    chk("stuck_null_driven", carry_in, 2'b00);
    fault_null = 1'b0;

    // Illegal 2'b11 pair also ends in an error response.
    fault_ill = 1'b1;
    do_cmd(1'b1, 8'd2, 0, v, c, e, dc);
    chk("illegal_err", e, 1);
    fault_ill = 1'b0;

    // Asynchronous reset while parked in WAIT_DATA.
    fault_null = 1'b1;
    wait_ready();
    @(negedge clk); cmd_valid = 1'b1; cmd_op = 1'b1; cmd_count = 8'd4;
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("park_carry_in", carry_in, 2'b10);
    #2 init_n = 1'b0;
    #1;
    chk("async_ring_init", ring_init, 1);
    chk("async_ring_ki", ring_ki, 1);
    chk("async_carry_in", carry_in, 2'b00);
    chk("async_busy_ready", {busy, cmd_ready}, 2'b10);
    chk("async_rsp", {rsp_valid, rsp_carry, rsp_err, 28'(rsp_value)}, 0);
    fault_null = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); init_n = 1'b1;

    // Wrap: 17 increments of a 4-bit ring from 0.
    do_cmd(1'b1, 8'd17, 0, v, c, e, dc);
    chk("wrap_value", v, 1);
    chk("wrap_carry", c, 1);
    chk("wrap_err", e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
